sliding_sprite: RTL and testbench

Parametrised horizontally sliding sprite engine: the generalised successor of the single-purpose door slider. It keeps an on-screen X position for a fixed-size sprite and moves it once per frame, either from keyboard keycodes (manual mode) or under a command-driven open/close state machine (auto mode). Per pixel it produces a registered visibility flag and sprite-ROM address for the colour mapper. It sits between the keycode/scene-status logic and the sprite ROM and colour mapper.

---
 rtl/sliding_sprite_if.sv | 29 ++
 rtl/sliding_sprite.sv | 140 ++++++++++++++
 tb/tb_sliding_sprite.sv | 376 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sliding_sprite_if.sv
// Control and draw bus of the sliding sprite engine: frame/command/key inputs
// and the per-pixel draw request with its registered response.
interface sliding_sprite_if #(
  parameter int ADDR_W = 20
);
  logic              frame_clk;
  logic              mode;
  logic              cmd_open;
  logic              cmd_close;
  logic [7:0]        keycode;
  logic [3:0]        status;
  logic [9:0]        DrawX;
  logic [9:0]        DrawY;
  logic              is_sprite;
  logic [ADDR_W-1:0] sprite_address;
  logic [9:0]        pos_x;
  logic [2:0]        state;
  logic              done;

  modport master (
    output frame_clk, mode, cmd_open, cmd_close, keycode, status, DrawX, DrawY,
    input  is_sprite, sprite_address, pos_x, state, done
  );

  modport slave (
    input  frame_clk, mode, cmd_open, cmd_close, keycode, status, DrawX, DrawY,
    output is_sprite, sprite_address, pos_x, state, done
  );
endinterface

// File: rtl/sliding_sprite.sv
// Horizontally sliding sprite: per-frame X movement (keycode or open/close FSM)
// and registered per-pixel visibility / sprite-ROM address.
module sliding_sprite #(
  parameter int          SPR_W        = 182,
  parameter int          SPR_H        = 158,
  parameter int          Y_TOP        = 22,
  parameter int          X_INIT       = 698,
  parameter int          X_MIN        = 458,
  parameter int          X_MAX        = 698,
  parameter int          STEP         = 1,
  parameter int          SCREEN_W     = 640,
  parameter int          STATUS_MATCH = 3,
  parameter logic [7:0]  KEY_DEC      = 8'd07,
  parameter logic [7:0]  KEY_INC      = 8'd04,
  parameter int          ADDR_W       = 20
) (
  input logic           Clk,
  input logic           Reset,
  sliding_sprite_if.slave bus
);

  typedef enum logic [2:0] {
    CLOSED  = 3'd0,
    OPENING = 3'd1,
    OPEN    = 3'd2,
    CLOSING = 3'd3,
    PARKED  = 3'd4
  } state_e;

  localparam logic [10:0] XMIN_C   = 11'(X_MIN);
  localparam logic [10:0] XMAX_C   = 11'(X_MAX);
  localparam logic [10:0] STEP_C   = 11'(STEP);
  localparam logic [10:0] XINIT_C  = 11'(X_INIT);
  localparam logic [10:0] SPRW_C   = 11'(SPR_W);
  localparam logic [10:0] SCRW_C   = 11'(SCREEN_W);
  localparam logic [10:0] YTOP_C   = 11'(Y_TOP);
  localparam logic [10:0] YEND_C   = 11'(Y_TOP + SPR_H);
  localparam logic [3:0]  STATUS_C = 4'(STATUS_MATCH);
  localparam state_e      RESET_ST = (X_INIT >= X_MAX) ? CLOSED :
                                     (X_INIT <= X_MIN) ? OPEN : PARKED;

  function automatic state_e pos_state(input logic [10:0] p);
    if (p == XMAX_C)      return CLOSED;
    else if (p == XMIN_C) return OPEN;
    else                  return PARKED;
  endfunction

  logic              sync1_q, sync2_q, sync3_q;
  logic              tick;
  logic [10:0]       pos_q, pos_d;
  state_e            state_q, state_d;
  logic              done_q, done_d;
  logic [10:0]       dec, inc;
  logic              is_sprite_q, is_sprite_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [10:0]       dx, dy, drawx11, drawy11;

  assign tick = sync2_q & ~sync3_q;

  always_comb begin
    dec = (pos_q < XMIN_C + STEP_C) ? XMIN_C : pos_q - STEP_C;
    inc = (pos_q + STEP_C > XMAX_C) ? XMAX_C : pos_q + STEP_C;
  end

  // Command transition is resolved first so a same-cycle tick moves in the new direction.
  always_comb begin
    pos_d   = pos_q;
    state_d = state_q;
    done_d  = 1'b0;
    if (!bus.mode) begin
      if (tick && bus.keycode == KEY_DEC)      pos_d = dec;
      else if (tick && bus.keycode == KEY_INC) pos_d = inc;
      state_d = pos_state(pos_d);
    end else begin
      if (bus.cmd_open) begin
        if (state_q inside {CLOSED, CLOSING, PARKED}) state_d = OPENING;
      end else if (bus.cmd_close) begin
        if (state_q inside {OPEN, OPENING, PARKED}) state_d = CLOSING;
      end
      if (tick) begin
        if (state_d == OPENING) begin
          pos_d = dec;
          if (dec == XMIN_C) begin
            state_d = OPEN;
            done_d  = 1'b1;
          end
        end else if (state_d == CLOSING) begin
          pos_d = inc;
          if (inc == XMAX_C) begin
            state_d = CLOSED;
            done_d  = 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    drawx11     = {1'b0, bus.DrawX};
    drawy11     = {1'b0, bus.DrawY};
    dx          = drawx11 - pos_q;
    dy          = drawy11 - YTOP_C;
    // dx[10] is the sign of DrawX - pos_x; negative offsets are left of the sprite.
    is_sprite_d = !dx[10] && (dx < SPRW_C) && (drawx11 < SCRW_C) &&
                  (drawy11 >= YTOP_C) && (drawy11 < YEND_C) &&
                  (bus.status == STATUS_C);
    addr_d      = '0;
    if (is_sprite_d)
      addr_d = ADDR_W'(dx) + ADDR_W'(dy) * ADDR_W'(SPR_W);
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      sync3_q     <= 1'b0;
      pos_q       <= XINIT_C;
      state_q     <= RESET_ST;
      done_q      <= 1'b0;
      is_sprite_q <= 1'b0;
      addr_q      <= '0;
    end else begin
      sync1_q     <= bus.frame_clk;
      sync2_q     <= sync1_q;
      sync3_q     <= sync2_q;
      pos_q       <= pos_d;
      state_q     <= state_d;
      done_q      <= done_d;
      is_sprite_q <= is_sprite_d;
      addr_q      <= addr_d;
    end
  end

  assign bus.pos_x          = pos_q[9:0];
  assign bus.state          = state_q;
  assign bus.done           = done_q;
  assign bus.is_sprite      = is_sprite_q;
  assign bus.sprite_address = addr_q;

endmodule

// File: tb/tb_sliding_sprite.sv
// Randomised self-checking bench for sliding_sprite: two instances (STEP=1 and
// STEP=7) checked against a position/state/draw reference model.
module tb_sliding_sprite;
  localparam int XMIN = 458, XMAX = 698, SPRW = 182, SPRH = 158, YTOP = 22;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sliding_sprite_if #(.ADDR_W(20)) b1 ();
  sliding_sprite_if #(.ADDR_W(20)) b7 ();

  sliding_sprite dut1 (.Clk(clk), .Reset(rst_n), .bus(b1));
  sliding_sprite #(.STEP(7)) dut7 (.Clk(clk), .Reset(rst_n), .bus(b7));

  int checks = 0;
  int errors = 0;
  int m_pos[2];
  int m_st[2];
  int m_step[2] = '{1, 7};
  int m_done[2] = '{0, 0};
  int dcnt[2] = '{0, 0};
  int consec = 0;
  logic prev_d1 = 1'b0, prev_d7 = 1'b0;

  always @(negedge clk) begin
    if (b1.done) dcnt[0]++;
    if (b7.done) dcnt[1]++;
    if ((b1.done && prev_d1) || (b7.done && prev_d7)) consec++;
    prev_d1 = b1.done;
    prev_d7 = b7.done;
  end

  // ---------------- reference model ----------------
  function automatic int clampx(int v);
    return (v < XMIN) ? XMIN : ((v > XMAX) ? XMAX : v);
  endfunction

  function automatic int where_state(int p);
    return (p == XMAX) ? 0 : ((p == XMIN) ? 2 : 4);
  endfunction

  function automatic int get_pos(int i);
    return (i == 0) ? int'(b1.pos_x) : int'(b7.pos_x);
  endfunction

  function automatic int get_st(int i);
    return (i == 0) ? int'(b1.state) : int'(b7.state);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_pos[i] = 698;
      m_st[i]  = 0;
    end
  endtask

  task automatic model_tick();
    for (int i = 0; i < 2; i++) begin
      logic       md;
      logic [7:0] key;
      md  = (i == 0) ? b1.mode : b7.mode;
      key = (i == 0) ? b1.keycode : b7.keycode;
      if (!md) begin
        if (key == 8'd7)      m_pos[i] = clampx(m_pos[i] - m_step[i]);
        else if (key == 8'd4) m_pos[i] = clampx(m_pos[i] + m_step[i]);
        m_st[i] = where_state(m_pos[i]);
      end else if (m_st[i] == 1) begin
        m_pos[i] = clampx(m_pos[i] - m_step[i]);
        if (m_pos[i] == XMIN) begin m_st[i] = 2; m_done[i]++; end
      end else if (m_st[i] == 3) begin
        m_pos[i] = clampx(m_pos[i] + m_step[i]);
        if (m_pos[i] == XMAX) begin m_st[i] = 0; m_done[i]++; end
      end
    end
  endtask

  // ---------------- stimulus primitives ----------------
  task automatic frame();
    @(negedge clk);
    b1.frame_clk = 1'b1;
    b7.frame_clk = 1'b1;
    repeat (5) @(negedge clk);
    b1.frame_clk = 1'b0;
    b7.frame_clk = 1'b0;
    repeat (4) @(negedge clk);
    model_tick();
  endtask

  task automatic pulse_cmd(input int i, input bit o, input bit c);
    @(negedge clk);
    if (i == 0) begin b1.cmd_open = o; b1.cmd_close = c; end
    else        begin b7.cmd_open = o; b7.cmd_close = c; end
    @(negedge clk);
    b1.cmd_open = 1'b0; b1.cmd_close = 1'b0;
    b7.cmd_open = 1'b0; b7.cmd_close = 1'b0;
    if (o) begin
      if (m_st[i] == 0 || m_st[i] == 3 || m_st[i] == 4) m_st[i] = 1;
    end else if (c) begin
      if (m_st[i] == 2 || m_st[i] == 1 || m_st[i] == 4) m_st[i] = 3;
    end
  endtask

  task automatic set_mode(input int i, input logic m);
    @(negedge clk);
    if (i == 0) b1.mode = m; else b7.mode = m;
    @(negedge clk);
    if (!m) m_st[i] = where_state(m_pos[i]);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (get_pos(i) !== 698) begin errors++; $display("FAIL reset_pos[%0d] got %0d exp 698", i, get_pos(i)); end
      checks++;
      if (get_st(i) !== 0) begin errors++; $display("FAIL reset_state[%0d] got %0d exp 0", i, get_st(i)); end
    end
    checks++;
    if (b1.is_sprite !== 1'b0 || b1.sprite_address !== 20'd0 || b1.done !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs got is_sprite=%0b addr=%0d done=%0b exp 0 0 0", b1.is_sprite, b1.sprite_address, b1.done);
    end
    rst_n = 1'b1;
    model_reset();
    repeat (10) frame();
    checks++;
    if (b1.pos_x !== 10'd698) begin errors++; $display("FAIL idle_pos got %0d exp 698", b1.pos_x); end
  endtask

  task automatic test_manual();
    b1.keycode = 8'd7;
    for (int f = 0; f < 250; f++) begin
      frame();
      checks++;
      if (get_pos(0) !== m_pos[0] || get_st(0) !== m_st[0]) begin
        errors++;
        $display("FAIL manual_dec frame %0d got pos=%0d st=%0d exp pos=%0d st=%0d", f, get_pos(0), get_st(0), m_pos[0], m_st[0]);
      end
    end
    checks++;
    if (b1.pos_x !== 10'd458) begin errors++; $display("FAIL manual_clamp_min got %0d exp 458", b1.pos_x); end
    b1.keycode = 8'd4;
    repeat (3) frame();
    checks++;
    if (b1.pos_x !== 10'd461 || b1.state !== 3'd4) begin
      errors++;
      $display("FAIL manual_inc3 got pos=%0d st=%0d exp pos=461 st=4", b1.pos_x, b1.state);
    end
  endtask

  task automatic test_manual_random();
    for (int f = 0; f < 40; f++) begin
      for (int i = 0; i < 2; i++) begin
        logic [7:0] k;
        case ($urandom_range(0, 3))
          0, 3:    k = 8'd7;
          1:       k = 8'd4;
          default: k = 8'($urandom);
        endcase
        if (i == 0) b1.keycode = k; else b7.keycode = k;
      end
      frame();
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (get_pos(i) !== m_pos[i] || get_st(i) !== m_st[i]) begin
          errors++;
          $display("FAIL manual_rand[%0d] frame %0d got pos=%0d st=%0d exp pos=%0d st=%0d", i, f, get_pos(i), get_st(i), m_pos[i], m_st[i]);
        end
      end
    end
    b1.keycode = 8'd0;
    b7.keycode = 8'd0;
    checks++;
    if (b1.done !== 1'b0 || dcnt[0] !== 0 || dcnt[1] !== 0) begin
      errors++;
      $display("FAIL manual_no_done got count=%0d/%0d exp 0/0", dcnt[0], dcnt[1]);
    end
  endtask

  task automatic test_auto_open();
    do_reset();
    set_mode(0, 1'b1);
    pulse_cmd(0, 1'b1, 1'b0);
    checks++;
    if (b1.state !== 3'd1) begin errors++; $display("FAIL auto_open_cmd got %0d exp 1", b1.state); end
    repeat (239) frame();
    checks++;
    if (get_pos(0) !== 459 || get_st(0) !== 1) begin
      errors++;
      $display("FAIL auto_open_239 got pos=%0d st=%0d exp pos=459 st=1", get_pos(0), get_st(0));
    end
    frame();
    checks++;
    if (get_pos(0) !== m_pos[0] || get_st(0) !== m_st[0] || m_pos[0] != XMIN) begin
      errors++;
      $display("FAIL auto_open_end got pos=%0d st=%0d exp pos=%0d st=%0d", get_pos(0), get_st(0), m_pos[0], m_st[0]);
    end
    checks++;
    if (dcnt[0] !== m_done[0]) begin errors++; $display("FAIL auto_open_done got %0d exp %0d", dcnt[0], m_done[0]); end
    pulse_cmd(0, 1'b1, 1'b0);
    frame();
    checks++;
    if (get_st(0) !== 2 || get_pos(0) !== 458 || dcnt[0] !== m_done[0]) begin
      errors++;
      $display("FAIL auto_open_again got st=%0d pos=%0d done=%0d exp st=2 pos=458 done=%0d", get_st(0), get_pos(0), dcnt[0], m_done[0]);
    end
  endtask

  task automatic test_step7();
    set_mode(1, 1'b1);
    pulse_cmd(1, 1'b1, 1'b0);
    repeat (35) frame();
    checks++;
    if (get_pos(1) !== 458 || get_st(1) !== 2) begin
      errors++;
      $display("FAIL step7_open got pos=%0d st=%0d exp pos=458 st=2", get_pos(1), get_st(1));
    end
    pulse_cmd(1, 1'b0, 1'b1);
    checks++;
    if (get_st(1) !== 3) begin errors++; $display("FAIL step7_close_cmd got %0d exp 3", get_st(1)); end
    repeat (34) frame();
    checks++;
    if (get_pos(1) !== 696 || get_st(1) !== 3) begin
      errors++;
      $display("FAIL step7_34 got pos=%0d st=%0d exp pos=696 st=3", get_pos(1), get_st(1));
    end
    frame();
    checks++;
    if (get_pos(1) !== m_pos[1] || get_st(1) !== m_st[1] || m_pos[1] != XMAX) begin
      errors++;
      $display("FAIL step7_35 got pos=%0d st=%0d exp pos=%0d st=%0d", get_pos(1), get_st(1), m_pos[1], m_st[1]);
    end
    checks++;
    if (dcnt[1] !== m_done[1]) begin errors++; $display("FAIL step7_done got %0d exp %0d", dcnt[1], m_done[1]); end
    pulse_cmd(1, 1'b1, 1'b1);
    checks++;
    if (get_st(1) !== 1) begin errors++; $display("FAIL step7_both_cmd got %0d exp 1", get_st(1)); end
  endtask

  task automatic test_draw();
    set_mode(0, 1'b0);
    b1.keycode = 8'd4;
    repeat (142) frame();
    b1.keycode = 8'd0;
    checks++;
    if (b1.pos_x !== 10'd600 || b1.state !== 3'd4) begin
      errors++;
      $display("FAIL draw_setup got pos=%0d st=%0d exp pos=600 st=4", b1.pos_x, b1.state);
    end
    for (int n = 0; n < 48; n++) begin
      int x, y, s, exp_vis, exp_addr;
      case (n)
        0: begin x = 610; y = 30;  s = 3; end
        1: begin x = 640; y = 30;  s = 3; end
        2: begin x = 610; y = 30;  s = 2; end
        3: begin x = 599; y = 30;  s = 3; end
        4: begin x = 600; y = 22;  s = 3; end
        5: begin x = 639; y = 179; s = 3; end
        6: begin x = 620; y = 180; s = 3; end
        7: begin x = 620; y = 21;  s = 3; end
        default: begin
          x = $urandom_range(560, 700);
          y = $urandom_range(0, 200);
          s = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : 3;
        end
      endcase
      exp_vis  = (x >= m_pos[0] && x - m_pos[0] < SPRW && x < 640 &&
                  y >= YTOP && y < YTOP + SPRH && s == 3) ? 1 : 0;
      exp_addr = exp_vis ? ((x - m_pos[0]) + (y - YTOP) * SPRW) % (1 << 20) : 0;
      @(negedge clk);
      b1.DrawX = 10'(x); b1.DrawY = 10'(y); b1.status = 4'(s);
      @(negedge clk);
      checks++;
      if (int'(b1.is_sprite) !== exp_vis || int'(b1.sprite_address) !== exp_addr) begin
        errors++;
        $display("FAIL draw x=%0d y=%0d st=%0d got vis=%0d addr=%0d exp vis=%0d addr=%0d", x, y, s, b1.is_sprite, b1.sprite_address, exp_vis, exp_addr);
      end
    end
  endtask

  task automatic test_reset_mid_move();
    set_mode(0, 1'b1);
    pulse_cmd(0, 1'b1, 1'b0);
    repeat (50) frame();
    checks++;
    if (get_pos(0) !== 550 || get_st(0) !== 1) begin
      errors++;
      $display("FAIL mid_move_setup got pos=%0d st=%0d exp pos=550 st=1", get_pos(0), get_st(0));
    end
    b1.DrawX = 10'd560; b1.DrawY = 10'd30; b1.status = 4'd3;
    repeat (2) @(negedge clk);
    checks++;
    if (b1.is_sprite !== 1'b1) begin errors++; $display("FAIL mid_move_vis got %0b exp 1", b1.is_sprite); end
    rst_n = 1'b0;
    #1;
    checks++;
    if (b1.pos_x !== 10'd698 || b1.state !== 3'd0 || b1.done !== 1'b0 ||
        b1.is_sprite !== 1'b0 || b1.sprite_address !== 20'd0) begin
      errors++;
      $display("FAIL async_reset got pos=%0d st=%0d done=%0b vis=%0b addr=%0d exp 698 0 0 0 0", b1.pos_x, b1.state, b1.done, b1.is_sprite, b1.sprite_address);
    end
    b1.DrawX = 10'd0; b1.status = 4'd0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    repeat (3) frame();
    checks++;
    if (get_pos(0) !== 698 || get_st(0) !== 0) begin
      errors++;
      $display("FAIL post_reset_idle got pos=%0d st=%0d exp pos=698 st=0", get_pos(0), get_st(0));
    end
    pulse_cmd(0, 1'b1, 1'b0);
    frame();
    checks++;
    if (get_pos(0) !== m_pos[0] || get_st(0) !== m_st[0]) begin
      errors++;
      $display("FAIL post_reset_open got pos=%0d st=%0d exp pos=%0d st=%0d", get_pos(0), get_st(0), m_pos[0], m_st[0]);
    end
  endtask

  task automatic test_mode_switch();
    set_mode(0, 1'b0);
    checks++;
    if (get_st(0) !== m_st[0]) begin errors++; $display("FAIL mode_to_manual got %0d exp %0d", get_st(0), m_st[0]); end
    frame();
    checks++;
    if (get_pos(0) !== m_pos[0]) begin errors++; $display("FAIL manual_hold got %0d exp %0d", get_pos(0), m_pos[0]); end
    set_mode(0, 1'b1);
    checks++;
    if (get_st(0) !== m_st[0]) begin errors++; $display("FAIL mode_to_auto got %0d exp %0d", get_st(0), m_st[0]); end
    pulse_cmd(0, 1'b0, 1'b1);
    frame();
    checks++;
    if (get_pos(0) !== m_pos[0] || get_st(0) !== m_st[0]) begin
      errors++;
      $display("FAIL park_close got pos=%0d st=%0d exp pos=%0d st=%0d", get_pos(0), get_st(0), m_pos[0], m_st[0]);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (dcnt[0] !== m_done[0] || dcnt[1] !== m_done[1]) begin
      errors++;
      $display("FAIL done_total got %0d/%0d exp %0d/%0d", dcnt[0], dcnt[1], m_done[0], m_done[1]);
    end
    checks++;
    if (consec !== 0) begin errors++; $display("FAIL done_consecutive got %0d exp 0", consec); end
  endtask

  initial begin
    b1.frame_clk = 1'b0; b1.mode = 1'b0; b1.cmd_open = 1'b0; b1.cmd_close = 1'b0;
    b1.keycode = 8'd0; b1.status = 4'd0; b1.DrawX = 10'd0; b1.DrawY = 10'd0;
    b7.frame_clk = 1'b0; b7.mode = 1'b0; b7.cmd_open = 1'b0; b7.cmd_close = 1'b0;
    b7.keycode = 8'd0; b7.status = 4'd0; b7.DrawX = 10'd0; b7.DrawY = 10'd0;
    model_reset();
    test_reset();
    test_manual();
    test_manual_random();
    test_auto_open();
    test_step7();
    test_draw();
    test_reset_mid_move();
    test_mode_switch();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
